// File: rtl/mips_wback.sv
// mips_wback: write-back arbiter and long-latency scoreboard for the single
// write port of the 32-entry GPR file.
//
// Two result sources share the GPR write port:
//   - in-order pipeline results (pw_*). These have no backpressure and always
//     win arbitration.
//   - long-latency results (lw_*), e.g. mul/div. These are buffered in a small
//     FIFO and drained whenever the pipeline is not writing.
// The winning result is registered onto wr_en/wr_addr/wr_data.
//
// A 32-bit pending mask records destinations that are still owed a
// long-latency result. Decode uses busy_1/busy_2 to stall on them.
//
// Optional feature macro: MIPS_WBACK_FWD_EN
//   When defined, the write currently on wr_* is forwarded to decode through
//   fwd_n/fwd_data_n, and busy_n no longer covers that in-flight write.
//
// Handshake (long-op port):
//   - lw_ready depends only on buffer occupancy (never on lw_valid).
//   - A result is accepted on a posedge where lw_valid & lw_ready.
//   - lw_addr and lw_data are sampled on that same edge.
//   - The producer must hold its result while lw_valid & !lw_ready.
module mips_wback #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pw_en,
  input  logic [4:0]       pw_addr,
  input  logic [31:0]      pw_data,
  input  logic             lw_valid,
  output logic             lw_ready,
  input  logic [4:0]       lw_addr,
  input  logic [31:0]      lw_data,
  input  logic             iss_en,
  input  logic [4:0]       iss_addr,
  input  logic [4:0]       rd_addr_1,
  input  logic [4:0]       rd_addr_2,
  output logic             busy_1,
  output logic             busy_2,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] lq_cnt
`ifdef MIPS_WBACK_FWD_EN
  ,
  output logic             fwd_1,
  output logic [31:0]      fwd_data_1,
  output logic             fwd_2,
  output logic [31:0]      fwd_data_2
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Long-op result buffer storage. It is not reset: occupancy is tracked by
  // the pointers and the count, so stale entries are never read.
  logic [4:0]       q_addr [FIFO_DEPTH];
  logic [31:0]      q_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        q_empty;
  logic        push;
  logic        pop;

  logic [31:0] pending;
  logic [31:0] pending_nxt;

  logic inflight_1;
  logic inflight_2;

  // Buffer status, handshake and arbitration decisions
  always_comb begin
    q_empty   = (lq_cnt == CNT_ZERO);
    lw_ready  = (lq_cnt != CNT_FULL);
    push      = lw_valid & lw_ready;
    // The pipeline has no backpressure, so the buffer only drains on idle
    // pipeline cycles.
    pop       = ~pw_en & ~q_empty;
    head_addr = q_addr[rd_ptr];
    head_data = q_data[rd_ptr];
  end

  // Buffer storage write on accepted long-op result
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= lw_addr;
      q_data[wr_ptr] <= lw_data;
    end
  end

  // Buffer pointers and occupancy count. Pointers wrap naturally because
  // the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lq_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // A simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   lq_cnt <= lq_cnt + CNT_ONE;
        2'b01:   lq_cnt <= lq_cnt - CNT_ONE;
        default: lq_cnt <= lq_cnt;
      endcase
    end
  end

  // Registered write port. The pipeline wins, then the buffer head.
  // When idle, address and data hold their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (pw_en) begin
      wr_en   <= 1'b1;
      wr_addr <= pw_addr;
      wr_data <= pw_data;
    end else if (pop) begin
      wr_en   <= 1'b1;
      wr_addr <= head_addr;
      wr_data <= head_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Next pending mask
  always_comb begin
    pending_nxt = pending;
    // A popped result clears its pending bit.
    if (pop) pending_nxt[head_addr] = 1'b0;
    // A new issue to the same register overrides the pop clear, because the
    // new op supersedes the result being written back.
    if (iss_en && (iss_addr != 5'd0)) pending_nxt[iss_addr] = 1'b1;
    // r0 is hardwired zero and is never owed a result.
    pending_nxt[0] = 1'b0;
  end

  // Pending mask register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // In-flight detection: the value on wr_* reaches the GPR file only at the
  // next edge, so a read of that register this cycle would see stale data.
  always_comb begin
    inflight_1 = wr_en & (wr_addr == rd_addr_1);
    inflight_2 = wr_en & (wr_addr == rd_addr_2);
  end

`ifdef MIPS_WBACK_FWD_EN
  // Hazards with forwarding: the in-flight write is bypassed, so only
  // pending long ops stall decode.
  always_comb begin
    busy_1     = (rd_addr_1 != 5'd0) & pending[rd_addr_1];
    busy_2     = (rd_addr_2 != 5'd0) & pending[rd_addr_2];
    fwd_1      = inflight_1 & (rd_addr_1 != 5'd0);
    fwd_2      = inflight_2 & (rd_addr_2 != 5'd0);
    fwd_data_1 = wr_data;
    fwd_data_2 = wr_data;
  end
`else
  // Hazards without forwarding: stall on pending long ops and on the write
  // that is still in flight to the GPR file.
  always_comb begin
    busy_1 = (rd_addr_1 != 5'd0) & (pending[rd_addr_1] | inflight_1);
    busy_2 = (rd_addr_2 != 5'd0) & (pending[rd_addr_2] | inflight_2);
  end
`endif

endmodule

// File: tb/tb_mips_wback.sv
// Bench for mips_wback (default build: MIPS_WBACK_FWD_EN undefined).
// Stimulus is a table of one-cycle vectors with hand-computed post-edge
// expectations, followed by hand-written reset and write-order sequences.
module tb_mips_wback;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        pw_en;
  logic [4:0]  pw_addr;
  logic [31:0] pw_data;
  logic        lw_valid;
  logic        lw_ready;
  logic [4:0]  lw_addr;
  logic [31:0] lw_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic        busy_1;
  logic        busy_2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  lq_cnt;

  mips_wback #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .pw_en     (pw_en),
    .pw_addr   (pw_addr),
    .pw_data   (pw_data),
    .lw_valid  (lw_valid),
    .lw_ready  (lw_ready),
    .lw_addr   (lw_addr),
    .lw_data   (lw_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .busy_1    (busy_1),
    .busy_2    (busy_2),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lq_cnt    (lq_cnt)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        pe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_b1;
    logic        e_b2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic pe, input logic [4:0] pa, input logic [31:0] pd,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic ie, input logic [4:0] ia,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
    input logic [2:0] ec, input logic er, input logic eb1, input logic eb2);
    vec_t v;
    v.pe = pe; v.pa = pa; v.pd = pd;
    v.lv = lv; v.la = la; v.ld = ld;
    v.ie = ie; v.ia = ia; v.r1 = r1; v.r2 = r2;
    v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd;
    v.e_cnt = ec; v.e_rdy = er; v.e_b1 = eb1; v.e_b2 = eb2;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare an observed write against the head of the expected write stream.
  task automatic sb_observe();
    logic [36:0] e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb unexpected write: got %0h expected none", {wr_addr, wr_data});
      end else begin
        e = exp_q.pop_front();
        chk("sb write order", {27'd0, wr_addr, wr_data}, {27'd0, e});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    pw_en = 1'b0; pw_addr = '0; pw_data = '0;
    lw_valid = 1'b0; lw_addr = '0; lw_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    pw_en = v.pe; pw_addr = v.pa; pw_data = v.pd;
    lw_valid = v.lv; lw_addr = v.la; lw_data = v.ld;
    iss_en = v.ie; iss_addr = v.ia;
    rd_addr_1 = v.r1; rd_addr_2 = v.r2;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    rd_addr_1 = 5'd0;
    rd_addr_2 = 5'd0;

    // Power-on reset state.
    #12;
    chk("rst wr_en",    64'(wr_en),    64'd0);
    chk("rst wr_addr",  64'(wr_addr),  64'd0);
    chk("rst wr_data",  64'(wr_data),  64'd0);
    chk("rst lq_cnt",   64'(lq_cnt),   64'd0);
    chk("rst lw_ready", 64'(lw_ready), 64'd1);
    rst = 1'b0;

    // Fields: pe pa pd | lv la ld | ie ia | r1 r2 || we wa wd cnt rdy b1 b2
    // Pipeline write, then idle with hold.
    vecs.push_back(mk(1,7,32'hDEADBEEF, 0,0,0, 0,0, 7,0,  1,7,32'hDEADBEEF, 0,1,1,0));
    vecs.push_back(mk(0,0,0,            0,0,0, 0,0, 7,7,  0,7,32'hDEADBEEF, 0,1,0,0));
    // Issue r9, push its result three cycles later, drain.
    vecs.push_back(mk(0,0,0, 0,0,0,       1,9, 9,0,  0,7,32'hDEADBEEF, 0,1,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,       0,0, 9,0,  0,7,32'hDEADBEEF, 0,1,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,       0,0, 9,0,  0,7,32'hDEADBEEF, 0,1,1,0));
    vecs.push_back(mk(0,0,0, 1,9,32'h1234, 0,0, 9,0,  0,7,32'hDEADBEEF, 1,1,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,       0,0, 9,0,  1,9,32'h1234,     0,1,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,       0,0, 9,0,  0,9,32'h1234,     0,1,0,0));
    // Collision: long result waits behind two pipeline writes.
    vecs.push_back(mk(0,0,0,     1,3,32'hA, 0,0, 3,4,  0,9,32'h1234, 1,1,0,0));
    vecs.push_back(mk(1,4,32'hB, 0,0,0,     0,0, 3,4,  1,4,32'hB,    1,1,0,1));
    vecs.push_back(mk(1,4,32'hB, 0,0,0,     0,0, 3,4,  1,4,32'hB,    1,1,0,1));
    vecs.push_back(mk(0,0,0,     0,0,0,     0,0, 3,4,  1,3,32'hA,    0,1,1,0));
    vecs.push_back(mk(0,0,0,     0,0,0,     0,0, 3,4,  0,3,32'hA,    0,1,0,0));
    // Re-issue r12 in the same cycle its old result pops: stays pending.
    vecs.push_back(mk(0,0,0, 0,0,0,         1,12, 12,0,  0,3,32'hA,  0,1,1,0));
    vecs.push_back(mk(0,0,0, 1,12,32'h55,   0,0,  12,0,  0,3,32'hA,  1,1,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,         1,12, 12,0,  1,12,32'h55, 0,1,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,         0,0,  12,0,  0,12,32'h55, 0,1,1,0));
    // Pipeline write to r0 passes through; then r12 finally clears.
    vecs.push_back(mk(0,0,0,         1,12,32'h66, 0,0, 12,0,  0,12,32'h55,  1,1,1,0));
    vecs.push_back(mk(1,0,32'hCAFE,  0,0,0,       0,0, 12,0,  1,0,32'hCAFE, 1,1,1,0));
    vecs.push_back(mk(0,0,0,         0,0,0,       0,0, 12,0,  1,12,32'h66,  0,1,1,0));
    vecs.push_back(mk(0,0,0,         0,0,0,       0,0, 12,0,  0,12,32'h66,  0,1,0,0));
    // Fill the buffer behind pipeline writes; extra pushes are refused.
    vecs.push_back(mk(1,1,32'h100, 1,20,32'h20, 0,0, 20,23,  1,1,32'h100, 1,1,0,0));
    vecs.push_back(mk(1,1,32'h101, 1,21,32'h21, 0,0, 20,23,  1,1,32'h101, 2,1,0,0));
    vecs.push_back(mk(1,1,32'h102, 1,22,32'h22, 0,0, 20,23,  1,1,32'h102, 3,1,0,0));
    vecs.push_back(mk(1,1,32'h103, 1,23,32'h23, 0,0, 20,23,  1,1,32'h103, 4,0,0,0));
    vecs.push_back(mk(1,1,32'h104, 1,24,32'h24, 0,0, 20,23,  1,1,32'h104, 4,0,0,0));
    vecs.push_back(mk(0,0,0,       1,25,32'h25, 0,0, 20,23,  1,20,32'h20, 3,1,1,0));
    vecs.push_back(mk(0,0,0,       0,0,0,       0,0, 20,23,  1,21,32'h21, 2,1,0,0));
    vecs.push_back(mk(0,0,0,       0,0,0,       0,0, 20,23,  1,22,32'h22, 1,1,0,0));
    vecs.push_back(mk(0,0,0,       0,0,0,       0,0, 20,23,  1,23,32'h23, 0,1,0,1));
    vecs.push_back(mk(0,0,0,       0,0,0,       0,0, 20,23,  0,23,32'h23, 0,1,0,0));
    // Push and pop in the same cycle keep the count.
    vecs.push_back(mk(0,0,0, 1,30,32'h30, 0,0, 30,31,  0,23,32'h23, 1,1,0,0));
    vecs.push_back(mk(0,0,0, 1,31,32'h31, 0,0, 30,31,  1,30,32'h30, 1,1,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,       0,0, 30,31,  1,31,32'h31, 0,1,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,       0,0, 30,31,  0,31,32'h31, 0,1,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_vec(vecs[i]);
      tick();
      chk($sformatf("v%0d wr_en", i),    64'(wr_en),    64'(vecs[i].e_we));
      chk($sformatf("v%0d wr_addr", i),  64'(wr_addr),  64'(vecs[i].e_wa));
      chk($sformatf("v%0d wr_data", i),  64'(wr_data),  64'(vecs[i].e_wd));
      chk($sformatf("v%0d lq_cnt", i),   64'(lq_cnt),   64'(vecs[i].e_cnt));
      chk($sformatf("v%0d lw_ready", i), 64'(lw_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d busy_1", i),   64'(busy_1),   64'(vecs[i].e_b1));
      chk($sformatf("v%0d busy_2", i),   64'(busy_2),   64'(vecs[i].e_b2));
    end

    // Mid-stream reset with three buffered results and r5 pending.
    drive_idle();
    rd_addr_1 = 5'd5;
    rd_addr_2 = 5'd0;
    iss_en = 1'b1; iss_addr = 5'd5;
    tick();
    iss_en = 1'b0;
    pw_en = 1'b1; pw_addr = 5'd2; pw_data = 32'h2222;
    for (int k = 0; k < 3; k++) begin
      lw_valid = 1'b1; lw_addr = 5'(6 + k); lw_data = 32'h600 + 32'(k);
      tick();
    end
    drive_idle();
    chk("pre-rst lq_cnt", 64'(lq_cnt), 64'd3);
    chk("pre-rst busy_1", 64'(busy_1), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst wr_en",    64'(wr_en),    64'd0);
    chk("async rst wr_addr",  64'(wr_addr),  64'd0);
    chk("async rst wr_data",  64'(wr_data),  64'd0);
    chk("async rst lq_cnt",   64'(lq_cnt),   64'd0);
    chk("async rst lw_ready", 64'(lw_ready), 64'd1);
    chk("async rst busy_1",   64'(busy_1),   64'd0);
    #3;
    rst = 1'b0;
    tick();
    chk("post-rst wr_en",  64'(wr_en),  64'd0);
    chk("post-rst lq_cnt", 64'(lq_cnt), 64'd0);
    chk("post-rst busy_1", 64'(busy_1), 64'd0);
    tick();
    chk("post-rst wr_en 2", 64'(wr_en), 64'd0);

    // Write-stream ordering: pipeline writes first, then buffered results in
    // arrival order.
    pw_en = 1'b1; pw_addr = 5'd10; pw_data = 32'h1010;
    lw_valid = 1'b1; lw_addr = 5'd11; lw_data = 32'h1111;
    exp_q.push_back({5'd10, 32'h1010});
    tick();
    sb_observe();
    pw_addr = 5'd12; pw_data = 32'h1212;
    lw_addr = 5'd13; lw_data = 32'h1313;
    exp_q.push_back({5'd12, 32'h1212});
    tick();
    sb_observe();
    drive_idle();
    exp_q.push_back({5'd11, 32'h1111});
    exp_q.push_back({5'd13, 32'h1313});
    for (int k = 0; k < 3; k++) begin
      tick();
      sb_observe();
    end
    chk("sb queue drained", 64'(exp_q.size()), 64'd0);
    chk("sb final lq_cnt",  64'(lq_cnt),       64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
